// File: rtl/ps2_link_ctrl.sv
// PS/2 link controller: arbitrates a half-duplex PS/2 line between receive and transmit,
// buffers received bytes in a small FWFT FIFO and keeps sticky overrun/timeout flags.
module ps2_link_ctrl #(
  parameter int unsigned FIFO_W     = 2,
  parameter int unsigned TX_TIMEOUT = 2_000_000,
  parameter int unsigned GUARD      = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] wr_data,
  input  logic       rd_fifo,
  input  logic       clr_err,
  input  logic       rx_idle,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  output logic       rx_en,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [7:0] rd_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       tx_busy,
  output logic       overrun,
  output logic       tx_timeout
);

  localparam int unsigned DEPTH   = 1 << FIFO_W;
  localparam int unsigned CNT_MAX = (TX_TIMEOUT > GUARD) ? TX_TIMEOUT : GUARD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  GD_LAST  = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [FIFO_W:0]   FULL_CNT = (FIFO_W + 1)'(DEPTH);
  localparam logic [FIFO_W:0]   FCNT_ONE = (FIFO_W + 1)'(1);
  localparam logic [FIFO_W-1:0] PTR_ONE  = FIFO_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_REQ,
    TX_WAIT,
    TX_GUARD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_set;

  logic             tx_pend_q, tx_pend_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic [7:0]        mem_q [DEPTH];
  logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_W:0]   count_q, count_d;
  logic              push, pop, do_push, ovr_set;

  logic              overrun_q, overrun_d;
  logic              tx_timeout_q, tx_timeout_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_pend_q && rx_idle && tx_idle) state_d = TX_REQ;
        else if (!rx_idle)                   state_d = RX;
      end
      RX: begin
        if (rx_done_tick) state_d = IDLE;
      end
      TX_REQ: begin
        state_d = TX_WAIT;
        cnt_d   = '0;
      end
      TX_WAIT: begin
        if (tx_done_tick) begin
          state_d = TX_GUARD;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          to_set  = 1'b1;
          state_d = TX_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TX_GUARD: begin
        if (cnt_q == GD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rx_en    = 1'b1;
    tx_start = 1'b0;
    tx_busy  = tx_pend_q;
    case (state_q)
      TX_REQ: begin
        rx_en    = 1'b0;
        tx_start = 1'b1;
        tx_busy  = 1'b1;
      end
      TX_WAIT, TX_GUARD: begin
        rx_en   = 1'b0;
        tx_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------- TX holding register
  always_comb begin
    tx_pend_d = tx_pend_q;
    tx_data_d = tx_data_q;
    if (state_q == TX_REQ) tx_pend_d = 1'b0;
    if (wr_ps2 && !tx_busy) begin
      tx_pend_d = 1'b1;
      tx_data_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pend_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_pend_q <= tx_pend_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_data = tx_data_q;

  // ------------------------------------------------------------- RX FIFO
  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when accompanied by a pop; only an unmatched full push overruns.
  always_comb begin
    push     = rx_done_tick;
    pop      = rd_fifo && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || pop);
    ovr_set  = push && (count_q == FULL_CNT) && !pop;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + FCNT_ONE;
      2'b01:   count_d = count_q - FCNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= rx_dout;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign rx_empty = (count_q == '0);
  assign rx_full  = (count_q == FULL_CNT);

  // ---------------------------------------------------- sticky error flags
  always_comb begin
    overrun_d    = ovr_set ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    tx_timeout_d = to_set  ? 1'b1 : (clr_err ? 1'b0 : tx_timeout_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q    <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      overrun_q    <= overrun_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign overrun    = overrun_q;
  assign tx_timeout = tx_timeout_q;

endmodule

// File: doc/ps2_link_ctrl.md
PS2_LINK_CTRL -- requirements
Module: ps2_link_ctrl

Interface
REQ-001 Parameter FIFO_W, 2, log2 of RX FIFO depth (depth 4).
REQ-002 Parameter TX_TIMEOUT, 2_000_000, clk cycles allowed from tx_start to tx_done_tick (20 ms at 100 MHz).
REQ-003 Parameter GUARD, 100, clk cycles rx_en is held low after a TX ends.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 wr_ps2  in  1  CPU request to transmit wr_data; single-cycle strobe.
REQ-007 wr_data  in  8  byte to transmit.
REQ-008 rd_fifo  in  1  pop head of RX FIFO.
REQ-009 clr_err  in  1  clear sticky error flags.
REQ-010 rx_idle, rx_done_tick  in  1 each  receiver status and frame-complete tick.
REQ-011 rx_dout  in  8  received byte, valid with rx_done_tick.
REQ-012 tx_idle, tx_done_tick  in  1 each  transmitter status and frame-complete tick.
REQ-013 rx_en  out  1  receiver enable.
REQ-014 tx_start  out  1  one-cycle transmitter start pulse.
REQ-015 tx_data  out  8  byte presented to the transmitter, held stable from tx_start to the end of TX_WAIT.
REQ-016 rd_data  out  8  RX FIFO head (first-word fall-through).
REQ-017 rx_empty, rx_full  out  1 each  FIFO status.
REQ-018 tx_busy  out  1  TX holding register occupied or transfer in progress.
REQ-019 overrun, tx_timeout  out  1 each  sticky error flags.

Function
REQ-020 FSM states: IDLE, RX, TX_REQ, TX_WAIT, TX_GUARD.
REQ-021 IDLE: rx_en=1; if tx_pend=1 and rx_idle=1 and tx_idle=1 -> TX_REQ; else if rx_idle=0 -> RX. TX has priority when both conditions are true in the same cycle.
REQ-022 RX: rx_en=1; on rx_done_tick -> IDLE. No TX is launched while in RX.
REQ-023 TX_REQ: rx_en=0, tx_start=1 for exactly one cycle, tx_pend cleared; -> TX_WAIT.
REQ-024 TX_WAIT: rx_en=0; a cycle counter starts at 0. On tx_done_tick -> TX_GUARD. If the counter reaches TX_TIMEOUT-1 without tx_done_tick, set tx_timeout and go to TX_GUARD.
REQ-025 TX_GUARD: rx_en=0 for exactly GUARD cycles, then -> IDLE.
REQ-026 Holding register: when tx_busy=0, wr_ps2 loads wr_data into tx_data and sets tx_pend. When tx_busy=1, wr_ps2 is ignored and no flag changes.
REQ-027 tx_busy = tx_pend OR state in {TX_REQ, TX_WAIT, TX_GUARD}.
REQ-028 RX FIFO has 2^FIFO_W entries, with pointers of width FIFO_W that wrap modulo depth.
REQ-029 rx_done_tick pushes rx_dout in any state.
REQ-030 A push while full (without a pop) drops the byte and sets overrun.
REQ-031 rd_fifo while empty is ignored; pointers do not change.
REQ-032 Simultaneous push and pop: both are performed, including when the FIFO is full (no overrun) or empty (the byte is pushed; the pop is ignored).
REQ-033 rd_data reflects the new head one cycle after a pop or after a push into an empty FIFO.
REQ-034 clr_err clears overrun and tx_timeout next cycle. A set event in the same cycle wins over clr_err.
REQ-035 A tx_done_tick or rx_done_tick arriving in an unexpected state changes no state (an RX push still occurs).

Reset
REQ-036 On reset: state=IDLE, rx_en=1, tx_start=0, tx_data=0, tx_pend=0, tx_busy=0, FIFO pointers=0, rx_empty=1, rx_full=0, overrun=0, tx_timeout=0, counters=0.
REQ-037 Reset asserted mid-RX or mid-TX returns all of the above immediately; any partial frame and FIFO contents are discarded.

Verification
REQ-038 Push 0x1C, 0x32 via rx_done_tick, then pop twice -> rd_data 0x1C then 0x32; rx_empty=1 after the second pop.
REQ-039 Five pushes with depth 4 and no pops -> rx_full=1, overrun=1, the fifth byte is lost; pops return the first four in order.
REQ-040 wr_ps2 with 0xED while rx_idle=0 (RX in progress) -> no tx_start until after rx_done_tick; then tx_start is a one-cycle pulse with tx_data=0xED and rx_en=0.
REQ-041 TX with tx_done_tick never returned, TX_TIMEOUT=50 -> tx_timeout=1 fifty cycles after TX_WAIT entry; rx_en=0 for GUARD cycles; then IDLE; clr_err clears the flag.
REQ-042 Second wr_ps2 (0xF4) while tx_busy=1 -> ignored; tx_data remains the first byte.
REQ-043 Push and pop in the same cycle when full -> count unchanged, overrun=0; reset asserted during TX_WAIT -> IDLE, rx_en=1, rx_empty=1.
